combinador_destinos: RTL
========================

# combinador_destinos

Receive-side merger for the transmission layer. It drains the two destination FIFOs (D0, D1) that the routing arbiter fills, alternates between them round-robin, and re-sorts each 6-bit word into the VC0 or VC1 output FIFO according to the word's class bit. It closes the VC→D path back into D→VC, tracks per-class word counts, and honours almost-full backpressure from both VC FIFOs.

## Interface
Parameters:
- DATA_WIDTH, 6, word width
- CLASS_BIT, 4, word bit selecting the VC: 0 → VC0, 1 → VC1
- CNT_WIDTH, 8, width of each per-VC word counter

Ports:
- clk  input  1  clock; all logic on the rising edge
- reset_L  input  1  reset, synchronous, active-high: asserted = 1 (fixed)
- D0  input  DATA_WIDTH  D0 FIFO read data, valid the cycle after pop_D0
- D0_empty  input  1  D0 FIFO empty
- pop_D0  output  1  read strobe to D0 FIFO
- D1  input  DATA_WIDTH  D1 FIFO read data, valid the cycle after pop_D1
- D1_empty  input  1  D1 FIFO empty
- pop_D1  output  1  read strobe to D1 FIFO
- VC0_almost_full  input  1  VC0 FIFO has ≤2 free slots
- VC1_almost_full  input  1  VC1 FIFO has ≤2 free slots
- VC0_out  output  DATA_WIDTH  write data to VC0 FIFO (registered)
- push_VC0  output  1  write strobe to VC0 FIFO (registered)
- VC1_out  output  DATA_WIDTH  write data to VC1 FIFO (registered)
- push_VC1  output  1  write strobe to VC1 FIFO (registered)
- cnt_VC0  output  CNT_WIDTH  words pushed to VC0 since reset
- cnt_VC1  output  CNT_WIDTH  words pushed to VC1 since reset
- idle  output  1  high in IDLE state

## Operation
- FSM states: IDLE, ACTIVE, PAUSE.
  - IDLE → ACTIVE when either FIFO is non-empty and neither almost_full is set.
  - ACTIVE → PAUSE when any almost_full = 1.
  - ACTIVE → IDLE when both FIFOs are empty and no word is in flight.
  - PAUSE → ACTIVE when both almost_full = 0 and a FIFO is non-empty; PAUSE → IDLE when both almost_full = 0 and both FIFOs are empty.
- Pops are issued only in ACTIVE, and only when both almost_full = 0. The class of a word is unknown before the pop, so gating is conservative.
- Pop selection is combinational from the current registers and inputs. At most one pop per cycle.
  - Only one FIFO non-empty: pop that FIFO.
  - Both non-empty: pop the FIFO other than last_served.
  - last_served updates on each pop.
  - Never pop a FIFO whose empty = 1 in that cycle.
- Pipeline: the pop in cycle N is registered as pend_valid / pend_src. In cycle N+1 the word on D[pend_src] is sampled. The word is decoded on CLASS_BIT and written to VCx_out with push_VCx = 1 at cycle N+2.
- push_VC0 and push_VC1 are never high in the same cycle. The pushed word's bits are unchanged.
- cnt_VCx increments on each push_VCx and wraps modulo 2^CNT_WIDTH.
- Almost_full asserting while a word is in flight does not cancel the word; it is still pushed. The 2-slot margin covers this.

## Timing
- Reset at clk edge with reset_L = 1. Resulting values:
  - state = IDLE, idle = 1
  - pop_D0 = pop_D1 = 0
  - push_VC0 = push_VC1 = 0, VC0_out = VC1_out = 0
  - cnt_VC0 = cnt_VC1 = 0
  - pend_valid = 0, last_served = D1 (so D0 is served first)
- Reset mid-operation: in-flight words are discarded and not pushed. Outputs take their reset values on the next edge. pop is 0 while reset_L = 1.
- Latency: a pop in cycle N produces a push visible in cycle N+2. Sustained throughput is 1 word/cycle.
- The first pop occurs 1 cycle after entering ACTIVE (the state is registered).
- Simultaneous non-empty with backpressure clearing: the pop issues in the first cycle where state = ACTIVE and both almost_full = 0.
- Counter wrap: at 2^CNT_WIDTH − 1, the next push returns the counter to 0.

## Test plan
- Reset check: hold reset_L = 1 for 2 cycles with D0_empty = 0 → all outputs 0, idle = 1, no pop.
- Single source: D0 holds 0x05, 0x15, 0x07 with D1 empty → pushes are VC0 ← 0x05, VC1 ← 0x15, VC0 ← 0x07 (bit 4 routes), each 2 cycles after its pop. Then cnt_VC0 = 2, cnt_VC1 = 1, back to IDLE.
- Round-robin: D0 = {0x01, 0x02}, D1 = {0x11, 0x12}, both non-empty from reset → pop order D0, D1, D0, D1 → VC0: 0x01, 0x02 and VC1: 0x11, 0x12 in order.
- Backpressure: assert VC1_almost_full while streaming → pops stop in the same cycle, the one in-flight word is still pushed, state = PAUSE. Deassert → pops resume the next cycle with no loss or duplication.
- Reset mid-stream: assert reset_L = 1 one cycle after a pop → no push follows, counters read 0, idle = 1.
- Counter wrap: push 256 words of class VC0 → cnt_VC0 reads 0 and cnt_VC1 stays 0.

Source files
------------

// File: rtl/combinador_destinos.sv
// Receive-side merger: drains D0/D1 round-robin and re-sorts each word into
// VC0 or VC1 by its class bit, with almost-full backpressure and per-VC counts.
module combinador_destinos #(
  parameter int DATA_WIDTH = 6,
  parameter int CLASS_BIT  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] D0,
  input  logic                  D0_empty,
  output logic                  pop_D0,
  input  logic [DATA_WIDTH-1:0] D1,
  input  logic                  D1_empty,
  output logic                  pop_D1,
  input  logic                  VC0_almost_full,
  input  logic                  VC1_almost_full,
  output logic [DATA_WIDTH-1:0] VC0_out,
  output logic                  push_VC0,
  output logic [DATA_WIDTH-1:0] VC1_out,
  output logic                  push_VC1,
  output logic [CNT_WIDTH-1:0]  cnt_VC0,
  output logic [CNT_WIDTH-1:0]  cnt_VC1,
  output logic                  idle
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} state_t;

  state_t                state, state_next;
  logic                  last_served;
  logic                  pend_valid;
  logic                  pend_src;
  logic                  any_full;
  logic                  both_empty;
  logic                  pop_any;
  logic                  pop_sel;
  logic                  word_class;
  logic [DATA_WIDTH-1:0] word;

  assign any_full   = VC0_almost_full | VC1_almost_full;
  assign both_empty = D0_empty & D1_empty;
  assign idle       = (state == IDLE);
  assign word       = pend_src ? D1 : D0;
  assign word_class = word[CLASS_BIT];

  // Pop gating is conservative: the class of the next word is unknown until
  // it arrives, so either almost_full blocks both sources.
  always_comb begin
    pop_any = 1'b0;
    pop_sel = 1'b0;
    if (!reset_L && state == ACTIVE && !any_full && !both_empty) begin
      pop_any = 1'b1;
      if (!D0_empty && !D1_empty) pop_sel = ~last_served;
      else                        pop_sel = D0_empty;
    end
    pop_D0 = pop_any & ~pop_sel;
    pop_D1 = pop_any &  pop_sel;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!both_empty && !any_full) state_next = ACTIVE;
      ACTIVE: begin
        if (any_full)                       state_next = PAUSE;
        else if (both_empty && !pend_valid) state_next = IDLE;
      end
      PAUSE:   if (!any_full) state_next = both_empty ? IDLE : ACTIVE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      state       <= IDLE;
      last_served <= 1'b1;
      pend_valid  <= 1'b0;
      pend_src    <= 1'b0;
      push_VC0    <= 1'b0;
      push_VC1    <= 1'b0;
      VC0_out     <= '0;
      VC1_out     <= '0;
      cnt_VC0     <= '0;
      cnt_VC1     <= '0;
    end else begin
      state      <= state_next;
      pend_valid <= pop_any;
      pend_src   <= pop_sel;
      if (pop_any) last_served <= pop_sel;
      // The in-flight word is always delivered; the 2-slot margin absorbs it.
      push_VC0 <= pend_valid & ~word_class;
      push_VC1 <= pend_valid &  word_class;
      if (pend_valid && !word_class) begin
        VC0_out <= word;
        cnt_VC0 <= cnt_VC0 + CNT_WIDTH'(1);
      end
      if (pend_valid && word_class) begin
        VC1_out <= word;
        cnt_VC1 <= cnt_VC1 + CNT_WIDTH'(1);
      end
    end
  end

endmodule
